dct_2d_ctrl: RTL and testbench
==============================

Name: dct_2d_ctrl

Overview:
- Sequences one shared 8-point 1-D DCT core (instantiated alongside this block with INPUT_W=16) through a full 8x8 2-D transform.
- Row pass: accepts 8 pixel rows, pushes each through the core, and stores the results in an internal 8x8x16 transpose buffer.
- Column pass: presents the 8 buffer columns to the same core and streams the coefficients out through a registered valid/ready port.
- Sits between the pixel block fetcher and the quantiser in the JPEG pipeline.

Parameters:
- PIX_W, 8, pixel width; pixels are zero-extended to 16 bits for the core.
- COEF_W, 16, core and buffer word width. Fixed at 16; any other value is illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  row beat valid.
- in_ready  out  1  row beat accepted when in_valid && in_ready.
- in_row  in  8xPIX_W  8 pixels of one row; element 0 is leftmost.
- out_valid  out  1  column coefficient beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_col  out  8x16 signed  8 coefficients of one column.
- out_last  out  1  high with column 7 beat.
- dct_x_in  out  8x16  vector driven into the shared core.
- dct_x_out  in  8x16 signed  core result (combinational, same cycle).
- busy  out  1  high when state is not LOAD or row_cnt != 0.

Behaviour:
- Reset values:
  - state=LOAD, row_cnt=0, col_cnt=0.
  - in_ready=1, out_valid=0, out_last=0, out_col=0, busy=0.
  - dct_x_in=0. Buffer contents are don't-care.
- State LOAD:
  - in_ready=1; dct_x_in[i]={8'h00, in_row[i]}.
  - On handshake: buf[row_cnt][i] <= dct_x_out[i]; row_cnt increments.
  - On the handshake with row_cnt==7: row_cnt wraps to 0 and state moves to DRAIN next cycle.
  - No handshake: nothing changes.
- State DRAIN:
  - in_ready=0; dct_x_in[i]=buf[i][col_cnt].
  - Issue condition: out_valid==0 || out_ready==1.
  - On issue: out_col <= dct_x_out, out_valid <= 1, out_last <= (col_cnt==7), col_cnt increments.
  - Issue with col_cnt==7: col_cnt wraps to 0 and state moves to LOAD next cycle.
  - Handshake with no issue: out_valid <= 0.
- Output register stability: out_col and out_last stay stable while out_valid && !out_ready.
- Overlap with the next block:
  - Column 7 may still sit in the output register while LOAD accepts rows of the next block.
  - Permitted: the core and buffer are free once column 7 is captured.
  - The output register keeps handshaking independently in LOAD: out_valid clears on handshake.
- Latency:
  - Row 7 handshake at cycle T → column 0 issued at T+1 → out_valid high at T+2.
  - With out_ready held high, columns 0..7 appear on T+2..T+9 and in_ready returns high at T+9.
  - Minimum block period is 16 cycles.
- Arithmetic: none in this block beyond counters.
  - Buffer stores core output verbatim (16-bit two's complement, no saturation).
  - Column-pass overflow wraps exactly as the core does.
- Boundary conditions:
  - in_valid with in_ready=0 (DRAIN) is ignored; the source must hold its data.
  - out_ready is sampled every cycle, including in LOAD.
  - Asynchronous reset mid-block: all counters, state and output valid clear immediately; the partial block is discarded and no out_valid pulse is produced.

Test Plan:
- Reset/idle: assert rst_n=0 mid-DRAIN at column 3 → out_valid=0 and in_ready=1 immediately; after release, first handshake writes buffer row 0.
- Zero block: 8 back-to-back rows of 8'h00 → in_ready low from T+1; 8 beats out_col all 16'h0000 on T+2..T+9 with out_ready=1; out_last only on beat 8; in_ready=1 at T+9.
- Core drive check: in_row all 8'hFF during LOAD → dct_x_in all 16'h00FF; in DRAIN col 2, dct_x_in[i] equals buffer row i element 2 (check against the core golden model).
- Backpressure: out_ready=0 for 5 cycles while column 3 is valid → out_col/out_last stable, col_cnt held; column 4 appears the cycle after out_ready rises.
- Overlap: hold out_ready=0 on column 7 → state is LOAD, in_ready=1, and the next block's row 0 is accepted while column 7 is still held; column 7 is then consumed unchanged.
- Random pixels, 20 blocks, random in_valid/out_ready → output matches separable golden model (core row pass, then core column pass, 16-bit wrap), with in-order column sequencing.

Source files
------------

// File: rtl/dct_2d_ctrl.sv
// rtl/dct_2d_ctrl.sv - 8x8 2-D DCT sequencer around one shared 1-D DCT core
//
// Purpose: drives a shared combinational 8-point 1-D DCT core twice per block.
// The row pass writes core results into an 8x8 transpose buffer. The column
// pass reads buffer columns back through the core and streams coefficients
// out through a registered valid/ready port.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     row beat handshake; in_row holds 8 pixels, element 0 leftmost
//   out_valid/out_ready   column beat handshake; out_col holds 8 coefficients
//   out_last              high with the column 7 beat
//   dct_x_in              vector presented to the shared core
//   dct_x_out             core result, combinational from dct_x_in
//   busy                  high while a block is partly loaded or draining
module dct_2d_ctrl #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0][PIX_W-1:0]  in_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0][COEF_W-1:0] out_col,
    output logic                   out_last,
    output logic [7:0][COEF_W-1:0] dct_x_in,
    input  logic [7:0][COEF_W-1:0] dct_x_out,
    output logic                   busy
);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              row_cnt_q, row_cnt_d;
    logic [2:0]              col_cnt_q, col_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [7:0][COEF_W-1:0]  out_col_q, out_col_d;
    logic                    buf_we;

    // Transpose buffer: buf_q[row][col]. Contents need no reset; every
    // location is rewritten by the row pass before the column pass reads it.
    logic [7:0][COEF_W-1:0]  buf_q [8];

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_col_d   = out_col_q;
        buf_we      = 1'b0;
        in_ready    = 1'b0;
        dct_x_in    = '0;

        // The output register drains on its own in either state, so column 7
        // can linger while the next block is already being loaded.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    dct_x_in[i] = {{(COEF_W-PIX_W){1'b0}}, in_row[i]};
                end
                if (in_valid) begin
                    buf_we    = 1'b1;
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                for (int i = 0; i < 8; i++) begin
                    dct_x_in[i] = buf_q[i][col_cnt_q];
                end
                // Issue whenever the output register is empty or being emptied.
                if (!out_valid_q || out_ready) begin
                    out_col_d   = dct_x_out;
                    out_valid_d = 1'b1;
                    out_last_d  = (col_cnt_q == 3'd7);
                    col_cnt_d   = col_cnt_q + 3'd1;
                    if (col_cnt_q == 3'd7) begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Keep the core input quiet while reset is held.
        if (!rst_n) begin
            dct_x_in = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            row_cnt_q   <= 3'd0;
            col_cnt_q   <= 3'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_col_q   <= out_col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[row_cnt_q] <= dct_x_out;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_col   = out_col_q;
    assign busy      = (state_q != LOAD) || (row_cnt_q != 3'd0);

endmodule

// File: tb/tb_dct_2d_ctrl.sv
// tb/tb_dct_2d_ctrl.sv - self-checking bench for dct_2d_ctrl with a behavioural DCT core
module tb_dct_2d_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [7:0][7:0]  in_row;
    logic [7:0][15:0] out_col, dct_x_in, dct_x_out;

    dct_2d_ctrl #(.PIX_W(8), .COEF_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_last(out_last),
        .dct_x_in(dct_x_in), .dct_x_out(dct_x_out), .busy(busy)
    );

    // Cosine table scaled by 64: cos(m*pi/16) for m = 0..8.
    function automatic int cbase(input int m);
        case (m)
            0: return 64;
            1: return 63;
            2: return 59;
            3: return 53;
            4: return 45;
            5: return 36;
            6: return 24;
            7: return 12;
            default: return 0;
        endcase
    endfunction

    function automatic int cosv(input int m_in);
        int m;
        m = m_in % 32;
        if (m <= 8)       return cbase(m);
        else if (m <= 16) return -cbase(16 - m);
        else if (m <= 24) return -cbase(m - 16);
        else              return cbase(32 - m);
    endfunction

    // Shared 1-D core: y[k] = (sum_n cos((2n+1)k*pi/16)*64 * x[n]) >> 3, wrapped to 16 bits.
    function automatic logic [7:0][15:0] core8(input logic [7:0][15:0] x);
        logic [7:0][15:0] y;
        int acc;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) begin
                acc += cosv((2 * n + 1) * k) * int'($signed(x[n]));
            end
            acc = acc >>> 3;
            y[k] = acc[15:0];
        end
        return y;
    endfunction

    always_comb dct_x_out = core8(dct_x_in);

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: rows gathered per block, separable transform computed on completion.
    logic [7:0][7:0]  rows_q [$];
    logic [7:0][15:0] exp_col [$];
    logic             exp_last [$];
    logic [7:0][15:0] last_r [8];
    int               rx_beats = 0;
    logic             hold_q = 1'b0;
    logic [7:0][15:0] hold_col;
    logic             hold_last;
    logic [7:0][7:0]  blk [8];

    task automatic model_block();
        logic [7:0][15:0] w, v;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) w[i] = {8'h00, rows_q[r][i]};
            last_r[r] = core8(w);
        end
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 8; i++) v[i] = last_r[i][c];
            exp_col.push_back(core8(v));
            exp_last.push_back(c == 7);
        end
        rows_q.delete();
    endtask

    function automatic logic [7:0][15:0] colvec(input int c);
        logic [7:0][15:0] v;
        for (int i = 0; i < 8; i++) v[i] = last_r[i][c];
        return v;
    endfunction

    // One clock: drive at negedge, sample 1ns later, score handshakes due at the next posedge.
    task automatic cyc(input logic v, input logic [7:0][7:0] row, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        in_row    = row;
        out_ready = rdy;
        #1;
        if (hold_q) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_col", out_col, hold_col);
            check("hold_last", out_last, hold_last);
        end
        hold_q    = out_valid && !out_ready;
        hold_col  = out_col;
        hold_last = out_last;
        if (in_valid && in_ready) begin
            rows_q.push_back(in_row);
            if (rows_q.size() == 8) model_block();
        end
        if (out_valid && out_ready) begin
            rx_beats++;
            if (exp_col.size() == 0) begin
                check("unexpected_beat", out_valid, 1'b0);
            end else begin
                check("out_col", out_col, exp_col.pop_front());
                check("out_last", out_last, exp_last.pop_front());
            end
        end
    endtask

    task automatic rand_block();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) blk[r][i] = 8'($urandom);
    endtask

    task automatic load_block(input logic rdy);
        for (int r = 0; r < 8; r++) begin
            cyc(1'b1, blk[r], rdy);
            check("load_in_ready", in_ready, 1'b1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_col.size() > 0 && n < 200) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        check("drain_done", 128'(exp_col.size()), 128'd0);
    endtask

    typedef struct {
        logic [7:0][7:0]  row;
        logic [7:0][15:0] exp_x;
    } vec_t;
    vec_t tbl [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0][15:0] saved;
        logic [7:0][7:0]  cur;
        logic             have;
        int               sent, target, budget;

        tbl[0].row = 64'h0000000000000000; tbl[0].exp_x = 128'h0;
        tbl[1].row = 64'hFFFFFFFFFFFFFFFF; tbl[1].exp_x = 128'h00FF_00FF_00FF_00FF_00FF_00FF_00FF_00FF;
        tbl[2].row = 64'h0706050403020100; tbl[2].exp_x = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        tbl[3].row = 64'h80FF00017FFE1020; tbl[3].exp_x = 128'h0080_00FF_0000_0001_007F_00FE_0010_0020;

        // Reset values
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_row = '1;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_col", out_col, 128'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_dct_x_in", dct_x_in, 128'h0);
        in_valid = 1'b0; in_row = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Core drive in LOAD without handshake
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, tbl[j].row, 1'b0);
            check("load_dct_x_in", dct_x_in, tbl[j].exp_x);
            check("idle_in_ready", in_ready, 1'b1);
            check("idle_busy", busy, 1'b0);
        end

        // Zero block, timing from the row 7 handshake (step T)
        for (int r = 0; r < 8; r++) cyc(1'b1, '0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b0, '0, 1'b1);
            if (k == 1) begin
                check("zero_in_ready_low", in_ready, 1'b0);
                check("zero_valid_t1", out_valid, 1'b0);
            end else begin
                check("zero_valid", out_valid, 1'b1);
                check("zero_col", out_col, 128'h0);
                check("zero_last", out_last, k == 9);
            end
            if (k == 9) check("zero_in_ready_back", in_ready, 1'b1);
        end
        drain();

        // Column drive and backpressure on column 3
        rand_block();
        load_block(1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("drain_dct_x_in", dct_x_in, colvec(k - 1));
        end
        for (int s = 0; s < 5; s++) begin
            cyc(1'b0, '0, 1'b0);
            check("bp_valid", out_valid, 1'b1);
            check("bp_col3", out_col, exp_col[0]);
            check("bp_last", out_last, 1'b0);
            check("bp_col_cnt_held", dct_x_in, colvec(4));
        end
        cyc(1'b0, '0, 1'b1);
        saved = exp_col[0];
        cyc(1'b0, '0, 1'b1);
        check("bp_col4_next", out_col, saved);
        drain();

        // Overlap: column 7 held while the next block's row 0 is accepted
        rand_block();
        load_block(1'b1);
        for (int k = 1; k <= 8; k++) cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        check("ovl_last", out_last, 1'b1);
        check("ovl_in_ready", in_ready, 1'b1);
        check("ovl_busy_idle", busy, 1'b0);
        saved = out_col;
        rand_block();
        cyc(1'b1, blk[0], 1'b0);
        check("ovl_row0_ready", in_ready, 1'b1);
        cyc(1'b0, '0, 1'b0);
        check("ovl_busy", busy, 1'b1);
        check("ovl_col7_held", out_col, saved);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("ovl_valid_clear", out_valid, 1'b0);
        for (int r = 1; r < 8; r++) cyc(1'b1, blk[r], 1'b1);
        drain();

        // Asynchronous reset in the middle of the column pass
        rand_block();
        load_block(1'b1);
        for (int k = 1; k <= 4; k++) cyc(1'b0, '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        rows_q.delete(); exp_col.delete(); exp_last.delete(); hold_q = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("post_rst_no_valid", out_valid, 1'b0);
        end
        rand_block();
        load_block(1'b1);
        drain();

        // Random traffic: 20 blocks
        sent = 0; budget = 0; have = 1'b0; cur = '0;
        target = rx_beats + 160;
        while (rx_beats < target && budget < 20000) begin
            if (!have && sent < 160 && $urandom_range(0, 3) != 0) begin
                for (int i = 0; i < 8; i++) cur[i] = 8'($urandom);
                have = 1'b1;
            end
            cyc(have, cur, $urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                have = 1'b0;
                sent++;
            end
            budget++;
        end
        check("random_beats", 128'(rx_beats), 128'(target));
        check("random_queue_empty", 128'(exp_col.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
